instr_fetch_queue: RTL and testbench

- Fetch stage of the pipelined RISC-V core, directly upstream of decode.
- Issues word-aligned instruction-memory requests through a valid/ready request channel.
- Buffers in-order responses in a small FIFO and presents {instr, pc, pc+4} to decode. Decode's control unit and immediate extender consume `instr` unchanged.
- Handles control-flow redirects by flushing the queue and discarding stale in-flight responses.

---
 rtl/ifq_pkg.sv | 27 ++
 rtl/ifq_fifo.sv | 64 ++++++
 rtl/instr_fetch_queue.sv | 183 ++++++++++++++++++
 tb/tb_instr_fetch_queue.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifq_pkg.sv
// ============================================================================
// Module   : ifq_pkg
// Purpose  : Shared types and constants for the instruction fetch queue.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ifq_pkg;

    typedef logic [31:0] pc_t;

    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        HALT  = 1'b1
    } ifq_state_e;

    typedef struct packed {
        logic [31:0] instr;
        pc_t         pc;
        logic        misaligned;
    } ifq_entry_t;

endpackage

`default_nettype wire

// File: rtl/ifq_fifo.sv
// ============================================================================
// Module   : ifq_fifo
// Purpose  : Circular FIFO with synchronous flush; a push in the flush cycle
//            lands in the emptied queue.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ifq_fifo
    import ifq_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type         T     = ifq_entry_t
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  T                             push_data_i,
    input  logic                         pop_i,
    output T                             head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    T                mem_q [DEPTH];
    logic [AW-1:0]   rd_ptr_q;
    logic [AW-1:0]   wr_ptr_q;
    logic [CW-1:0]   count_q;
    logic [AW-1:0]   w_wr_idx;

    assign w_wr_idx = flush_i ? '0 : wr_ptr_q;

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[w_wr_idx] <= push_data_i;
        end
    end

    // Pointers are AW bits wide, so they wrap at DEPTH (a power of two).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= AW'(push_i);
            count_q  <= CW'(push_i);
        end else begin
            rd_ptr_q <= rd_ptr_q + AW'(pop_i);
            wr_ptr_q <= wr_ptr_q + AW'(push_i);
            count_q  <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/instr_fetch_queue.sv
// ============================================================================
// Module   : instr_fetch_queue
// Purpose  : Fetch stage: issues imem requests, queues responses for decode,
//            flushes on redirect. IFQ_MISALIGN_TRAP_EN adds the misaligned trap.
// Revision : 1.0
// ============================================================================
`default_nettype none

module instr_fetch_queue
    import ifq_pkg::*;
#(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc_plus4
`ifdef IFQ_MISALIGN_TRAP_EN
    ,
    output logic        instr_misaligned
`endif
);

    localparam int unsigned CW = $clog2(DEPTH+1);
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING+1);

    ifq_state_e   state_q, state_d;
    pc_t          fetch_pc_q, fetch_pc_d;
    pc_t          rsp_pc_q, rsp_pc_d;
    logic [OW-1:0] out_q, out_d;
    logic [OW-1:0] drop_q, drop_d;

    logic         w_req_fire;
    logic         w_rsp_drop;
    logic         w_rsp_accept;
    logic         w_trap;
    logic         w_push;
    logic         w_pop;
    logic         w_head_valid;
    pc_t          w_redirect_pc;
    logic [31:0]  w_inflight;
    ifq_entry_t   w_push_entry;
    ifq_entry_t   w_head;
    logic [CW-1:0] w_count;

    assign w_redirect_pc = redirect_pc & 32'hFFFF_FFFC;

`ifdef IFQ_MISALIGN_TRAP_EN
    assign w_trap = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
    assign w_trap = 1'b0;
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            state_d = w_trap ? HALT : FETCH;
        end
    end

    // ---------------- FSM: outputs ----------------
    // Credit covers queued entries plus in-flight requests, ignoring a same-cycle pop.
    assign w_inflight = 32'(w_count) + 32'(out_q);

    always_comb begin
        imem_req_valid = 1'b0;
        if (rst_n && !redirect_valid && (state_q == FETCH) &&
            (32'(out_q) < MAX_OUTSTANDING) && (w_inflight < DEPTH)) begin
            imem_req_valid = 1'b1;
        end
    end

    assign imem_req_addr = fetch_pc_q;
    assign w_req_fire    = imem_req_valid && imem_req_ready;
    assign w_rsp_drop    = imem_rsp_valid && (redirect_valid || (drop_q != '0));
    assign w_rsp_accept  = imem_rsp_valid && !w_rsp_drop;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        out_d      = out_q;
        drop_d     = drop_q;
        if (w_req_fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (w_rsp_accept) begin
            rsp_pc_d = rsp_pc_q + 32'd4;
        end
        case ({w_req_fire, imem_rsp_valid})
            2'b10:   out_d = out_q + OW'(1);
            2'b01:   out_d = out_q - OW'(1);
            default: out_d = out_q;
        endcase
        // Every response still in flight after a redirect belongs to the old path.
        if (redirect_valid) begin
            fetch_pc_d = w_redirect_pc;
            rsp_pc_d   = w_redirect_pc;
            drop_d     = out_d;
        end else if (imem_rsp_valid && (drop_q != '0)) begin
            drop_d = drop_q - OW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            out_q      <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
        end
    end

    always_comb begin
        w_push_entry.instr      = imem_rsp_data;
        w_push_entry.pc         = rsp_pc_q;
        w_push_entry.misaligned = 1'b0;
        if (w_trap) begin
            w_push_entry.instr      = RV_NOP;
            w_push_entry.pc         = redirect_pc;
            w_push_entry.misaligned = 1'b1;
        end
    end

    assign w_push = w_rsp_accept || w_trap;

    ifq_fifo #(
        .DEPTH (DEPTH),
        .T     (ifq_entry_t)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (redirect_valid),
        .push_i      (w_push),
        .push_data_i (w_push_entry),
        .pop_i       (w_pop),
        .head_o      (w_head),
        .count_o     (w_count)
    );

    assign w_head_valid   = (w_count != '0);
    assign instr_valid    = w_head_valid && !redirect_valid;
    assign w_pop          = instr_valid && instr_ready;
    assign instr          = w_head_valid ? w_head.instr : 32'd0;
    assign instr_pc       = w_head_valid ? w_head.pc    : 32'd0;
    assign instr_pc_plus4 = instr_pc + 32'd4 & {32{w_head_valid}};

`ifdef IFQ_MISALIGN_TRAP_EN
    assign instr_misaligned = w_head_valid ? w_head.misaligned : 1'b0;
`else
    logic w_unused_misaligned;
    assign w_unused_misaligned = w_head.misaligned;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
// ============================================================================
// Module   : tb_instr_fetch_queue
// Purpose  : Scoreboard bench for instr_fetch_queue with an in-order memory.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch_queue;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        mis;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus4;
`ifdef IFQ_MISALIGN_TRAP_EN
    logic        instr_misaligned;
`endif

    int          checks = 0;
    int          errors = 0;
    int          pop_cnt = 0;
    int          req_count = 0;
    bit          rsp_hold = 1'b0;
    exp_t        sb[$];
    logic [31:0] pend[$];
    exp_t        mon_e;

    instr_fetch_queue dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_pc_plus4 (instr_pc_plus4)
`ifdef IFQ_MISALIGN_TRAP_EN
        ,
        .instr_misaligned (instr_misaligned)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic push_stream(input logic [31:0] start, input int n);
        exp_t        e;
        logic [31:0] p;
        p = start;
        for (int i = 0; i < n; i++) begin
            e.instr = mem_word(p);
            e.pc    = p;
            e.mis   = 1'b0;
            sb.push_back(e);
            p = p + 32'd4;
        end
    endtask

    task automatic wait_pops(input int target);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (pop_cnt < target && n < 300);
        chk("pop_budget", 32'(pop_cnt >= target), 32'd1);
    endtask

    task automatic do_redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        @(negedge clk);
        chk("redir_instr_valid", 32'(instr_valid), 32'd0);
        chk("redir_req_valid", 32'(imem_req_valid), 32'd0);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        sb.delete();
    endtask

    // Memory model: answers each accepted request in order, one or more cycles later.
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        forever begin
            @(negedge clk);
            imem_rsp_valid = 1'b0;
            if (!rst_n) begin
                pend.delete();
            end else begin
                if (!rsp_hold && pend.size() > 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_word(pend.pop_front());
                end
                if (imem_req_valid && imem_req_ready) begin
                    pend.push_back(imem_req_addr);
                    req_count++;
                end
            end
        end
    end

    // Monitor: every decode handshake is compared with the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && instr_valid && instr_ready) begin
            pop_cnt++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got pc 0x%08h, expected no entry", instr_pc);
            end else begin
                mon_e = sb.pop_front();
                if (instr !== mon_e.instr || instr_pc !== mon_e.pc ||
                    instr_pc_plus4 !== (mon_e.pc + 32'd4)
`ifdef IFQ_MISALIGN_TRAP_EN
                    || instr_misaligned !== mon_e.mis
`endif
                    ) begin
                    errors++;
                    $display("FAIL pop_entry: got instr 0x%08h pc 0x%08h pc4 0x%08h, expected instr 0x%08h pc 0x%08h pc4 0x%08h",
                             instr, instr_pc, instr_pc_plus4, mon_e.instr, mon_e.pc, mon_e.pc + 32'd4);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int   base;
        int   rc;
        exp_t e;

        rst_n          = 1'b0;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_req_addr", imem_req_addr, 32'h0000_0000);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
        chk("rst_instr_pc4", instr_pc_plus4, 32'd0);

        // Startup latency and credit stall with decode not ready
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_stream(32'h0, 16);
        @(negedge clk);
        chk("c0_req_valid", 32'(imem_req_valid), 32'd1);
        chk("c0_req_addr", imem_req_addr, 32'h0);
        chk("c0_instr_valid", 32'(instr_valid), 32'd0);
        @(negedge clk);
        chk("c1_instr_valid", 32'(instr_valid), 32'd0);
        @(negedge clk);
        chk("c2_instr_valid", 32'(instr_valid), 32'd1);
        repeat (8) @(negedge clk);
        chk("stall_req_count", 32'(req_count), 32'd4);
        chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
        @(posedge clk);
        #1;
        instr_ready = 1'b1;
        wait_pops(8);

        // Hold memory responses: outstanding saturates, queue drains
        rsp_hold = 1'b1;
        repeat (8) @(negedge clk);
        chk("cap_req_valid", 32'(imem_req_valid), 32'd0);
        chk("cap_instr_valid", 32'(instr_valid), 32'd0);
        @(posedge clk);
        #1;
        do_redirect(32'h0000_0100);
        rsp_hold = 1'b0;
        push_stream(32'h100, 16);
        base = pop_cnt;
        wait_pops(base + 4);

        // Redirect coinciding with a response and decode ready on a non-empty queue
        instr_ready = 1'b0;
        rsp_hold    = 1'b1;
        repeat (4) @(negedge clk);
        chk("pre_redir_instr_valid", 32'(instr_valid), 32'd1);
        @(posedge clk);
        #1;
        instr_ready = 1'b1;
        rsp_hold    = 1'b0;
        base = pop_cnt;
        do_redirect(32'h0000_0200);
        chk("redir_no_pop", 32'(pop_cnt), 32'(base));
        push_stream(32'h200, 16);
        wait_pops(base + 4);

        // Address wrap
        do_redirect(32'hFFFF_FFF8);
        push_stream(32'hFFFF_FFF8, 8);
        base = pop_cnt;
        wait_pops(base + 5);

`ifdef IFQ_MISALIGN_TRAP_EN
        instr_ready = 1'b0;
        do_redirect(32'h0000_0102);
        e.instr = 32'h0000_0013;
        e.pc    = 32'h0000_0102;
        e.mis   = 1'b1;
        sb.push_back(e);
        rc = req_count;
        repeat (5) @(negedge clk);
        chk("halt_req_count", 32'(req_count), 32'(rc));
        chk("halt_req_valid", 32'(imem_req_valid), 32'd0);
        chk("halt_instr_valid", 32'(instr_valid), 32'd1);
        chk("halt_misaligned", 32'(instr_misaligned), 32'd1);
        @(posedge clk);
        #1;
        instr_ready = 1'b1;
        base = pop_cnt;
        wait_pops(base + 1);
        repeat (3) @(negedge clk);
        chk("halt_drained", 32'(instr_valid), 32'd0);
        chk("halt_req_count2", 32'(req_count), 32'(rc));
        @(posedge clk);
        #1;
        do_redirect(32'h0000_0400);
        push_stream(32'h400, 8);
        base = pop_cnt;
        wait_pops(base + 4);
`else
        rc = 0;
        e.mis = 1'b0;
        do_redirect(32'h0000_0306);
        push_stream(32'h304, 8);
        base = pop_cnt;
        wait_pops(base + 4);
`endif

        instr_ready = 1'b0;
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
